// File: rtl/modexp_host_pkg.sv
// Shared constants for the modular-exponentiation host: default operand
// geometry, the exponentiator's top-level state codes and the host FSM states.
package modexp_host_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int TOTAL_ADDR = 64;

   localparam logic [4:0] NONE          = 5'd0;
   localparam logic [4:0] LOADC         = 5'd1;
   localparam logic [4:0] WAIT_COMPUTE  = 5'd2;
   localparam logic [4:0] COMPLETE      = 5'd3;
   localparam logic [4:0] OUTPUT_RESULT = 5'd4;
   localparam logic [4:0] TERMINAL      = 5'd5;

   typedef enum logic [3:0] {
      IDLE,
      START_IN,
      LOAD,
      PAD,
      START_CALC,
      WAIT_DONE,
      GET_RES,
      CAPTURE,
      DONE,
      ERR
   } host_state_t;

endpackage

// File: rtl/modexp_host_if.sv
// Link between the host sequencer and the exponentiator: three one-cycle
// strobes plus the operand stream out, and state/result word back in.
interface modexp_host_if #(
   parameter int DATA_WIDTH = modexp_host_pkg::DATA_WIDTH
);

   logic                  start_input;
   logic                  start_compute;
   logic                  get_result;
   logic [DATA_WIDTH-1:0] mx_inp;
   logic [4:0]            mx_state;
   logic [DATA_WIDTH-1:0] mx_outp;

   modport master (
      output start_input,
      output start_compute,
      output get_result,
      output mx_inp,
      input  mx_state,
      input  mx_outp
   );

   modport slave (
      input  start_input,
      input  start_compute,
      input  get_result,
      input  mx_inp,
      output mx_state,
      output mx_outp
   );

endinterface

// File: rtl/word_buf.sv
// Simple word buffer: one synchronous write port, one combinational read port.
// Deliberately has no reset so stored operands/results survive a reset.
module word_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store one word per cycle when the write enable is raised.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/modexp_host.sv
// Host sequencer for the exponentiator: streams operand c out of c_buf,
// kicks off the computation, waits (optionally with a watchdog) for COMPLETE
// and collects the result words into res_buf for the host to read back.
module modexp_host #(
   parameter int DATA_WIDTH     = modexp_host_pkg::DATA_WIDTH,
   parameter int TOTAL_ADDR     = modexp_host_pkg::TOTAL_ADDR,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [$clog2(TOTAL_ADDR)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          go,
   input  logic [$clog2(TOTAL_ADDR)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout_err,
   modexp_host_if.master                 mx
);

   import modexp_host_pkg::*;

   localparam int AW   = $clog2(TOTAL_ADDR);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [AW-1:0] LAST_WORD = AW'(TOTAL_ADDR - 1);

   host_state_t           state, state_n;
   logic [AW-1:0]         word_cnt, word_cnt_n;
   logic [WD_W-1:0]       wd_cnt, wd_cnt_n;
   logic                  cap_wait, cap_wait_n;
   logic                  c_we, res_we;
   logic [DATA_WIDTH-1:0] c_rdata;

   word_buf #(.WIDTH(DATA_WIDTH), .DEPTH(TOTAL_ADDR)) u_c_buf (
      .clk   (clk),
      .we    (c_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (word_cnt),
      .rdata (c_rdata)
   );

   word_buf #(.WIDTH(DATA_WIDTH), .DEPTH(TOTAL_ADDR)) u_res_buf (
      .clk   (clk),
      .we    (res_we),
      .waddr (word_cnt),
      .wdata (mx.mx_outp),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // State and counter registers; reset returns to IDLE with all counts cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         word_cnt <= '0;
         wd_cnt   <= '0;
         cap_wait <= 1'b0;
      end else begin
         state    <= state_n;
         word_cnt <= word_cnt_n;
         wd_cnt   <= wd_cnt_n;
         cap_wait <= cap_wait_n;
      end
   end

   // Next-state and Moore outputs; COMPLETE is tested before the watchdog so
   // it wins a same-cycle tie, and the first CAPTURE cycle is skipped because
   // the exponentiator needs two cycles after get_result to present word 0.
   always_comb begin
      state_n           = state;
      word_cnt_n        = word_cnt;
      wd_cnt_n          = wd_cnt;
      cap_wait_n        = cap_wait;
      c_we              = 1'b0;
      res_we            = 1'b0;
      mx.start_input    = 1'b0;
      mx.start_compute  = 1'b0;
      mx.get_result     = 1'b0;
      mx.mx_inp         = '0;
      busy              = 1'b1;
      done              = 1'b0;
      timeout_err       = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            busy        = 1'b0;
            done        = (state == DONE);
            timeout_err = (state == ERR);
            c_we        = wr_en;
            if (go) begin
               state_n = START_IN;
            end
         end
         START_IN: begin
            mx.start_input = 1'b1;
            word_cnt_n     = '0;
            state_n        = LOAD;
         end
         LOAD: begin
            mx.mx_inp = c_rdata;
            if (word_cnt == LAST_WORD) begin
               state_n = PAD;
            end else begin
               word_cnt_n = word_cnt + AW'(1);
            end
         end
         PAD: begin
            state_n = START_CALC;
         end
         START_CALC: begin
            mx.start_compute = 1'b1;
            wd_cnt_n         = '0;
            state_n          = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (mx.mx_state == COMPLETE) begin
               state_n = GET_RES;
            end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
               state_n = ERR;
            end else if (wd_cnt != '1) begin
               wd_cnt_n = wd_cnt + WD_W'(1);
            end
         end
         GET_RES: begin
            mx.get_result = 1'b1;
            word_cnt_n    = '0;
            cap_wait_n    = 1'b1;
            state_n       = CAPTURE;
         end
         CAPTURE: begin
            if (cap_wait) begin
               cap_wait_n = 1'b0;
            end else begin
               res_we = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  state_n = DONE;
               end else begin
                  word_cnt_n = word_cnt + AW'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_modexp_host.sv
// Bench for modexp_host: dut_a has a 100-cycle watchdog, dut_b a 50-cycle one
// and shares every host input and exponentiator response with dut_a.
module tb_modexp_host;

   import modexp_host_pkg::*;

   localparam int DW = 64;
   localparam int N  = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en, go;
   logic [5:0]    wr_addr, rd_addr;
   logic [63:0]   wr_data;
   logic [63:0]   rd_data_a, rd_data_b;
   logic          busy_a, done_a, terr_a, busy_b, done_b, terr_b;
   logic [2:0]    strobes_a, strobes_b;
   logic [63:0]   c_model   [N];
   logic [63:0]   res_model [N];
   int            total = 0;
   int            bad   = 0;

   modexp_host_if #(.DATA_WIDTH(DW)) ifa ();
   modexp_host_if #(.DATA_WIDTH(DW)) ifb ();

   assign ifb.mx_state = ifa.mx_state;
   assign ifb.mx_outp  = ifa.mx_outp;
   assign strobes_a = {ifa.start_input, ifa.start_compute, ifa.get_result};
   assign strobes_b = {ifb.start_input, ifb.start_compute, ifb.get_result};

   modexp_host #(.DATA_WIDTH(DW), .TOTAL_ADDR(N), .TIMEOUT_CYCLES(100)) dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .rd_addr(rd_addr), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
      .timeout_err(terr_a), .mx(ifa)
   );

   modexp_host #(.DATA_WIDTH(DW), .TOTAL_ADDR(N), .TIMEOUT_CYCLES(50)) dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .rd_addr(rd_addr), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
      .timeout_err(terr_b), .mx(ifb)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Backstop so the run always ends even if the sequence somehow stalls.
   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation stalled");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [5:0] addr,
                                input logic [63:0] data, input logic g);
      @(negedge clk);
      wr_en   = we;
      wr_addr = addr;
      wr_data = data;
      go      = g;
   endtask

   // One host transaction against the model. complete_at=0 means the
   // exponentiator never reports COMPLETE; abort_word>=0 resets mid-capture.
   task automatic runOp(input int complete_at, input int abort_word, input bit check_b,
                        input bit intrude, input bit fixed_words);
      logic [63:0] word;
      bit          gr_seen;
      applyStimulus(1'b0, 6'd0, 64'd0, 1'b1);
      @(negedge clk);
      go = 1'b0;
      checkOutput("start_input", strobes_a, 3'b100);
      checkOutput("busy_after_go", busy_a, 1'b1);
      checkOutput("flags_cleared", {done_a, terr_a}, 2'b00);
      if (check_b) checkOutput("b_start_input", strobes_b, 3'b100);
      ifa.mx_state = LOADC;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         wr_en = 1'b0;
         go    = 1'b0;
         checkOutput($sformatf("load_word%0d", k), ifa.mx_inp, c_model[k]);
         checkOutput($sformatf("load_strobes%0d", k), strobes_a, 3'b000);
         if (intrude && k == 2) begin
            wr_en   = 1'b1;
            wr_addr = 6'd5;
            wr_data = 64'hDEAD;
            go      = 1'b1;
         end
      end
      @(negedge clk);
      checkOutput("pad_word", ifa.mx_inp, 64'd0);
      checkOutput("pad_strobes", strobes_a, 3'b000);
      @(negedge clk);
      checkOutput("start_compute", strobes_a, 3'b010);
      checkOutput("calc_mx_inp", ifa.mx_inp, 64'd0);
      if (check_b) checkOutput("b_start_compute", strobes_b, 3'b010);
      ifa.mx_state = WAIT_COMPUTE;
      gr_seen = 1'b0;
      if (complete_at == 0) begin
         for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            gr_seen |= ifa.get_result;
            if (n == 1 || n == 100) begin
               checkOutput($sformatf("wait_busy_%0d", n), busy_a, 1'b1);
               checkOutput($sformatf("wait_no_timeout_%0d", n), terr_a, 1'b0);
            end
         end
         @(negedge clk);
         checkOutput("timeout_flags", {busy_a, done_a, terr_a}, 3'b001);
         repeat (5) begin
            @(negedge clk);
            gr_seen |= ifa.get_result;
         end
         checkOutput("no_get_result_on_timeout", gr_seen, 1'b0);
         return;
      end
      for (int n = 1; n <= complete_at; n++) begin
         @(negedge clk);
         gr_seen |= ifa.get_result;
         if (n == complete_at) ifa.mx_state = COMPLETE;
      end
      checkOutput("no_early_get_result", gr_seen, 1'b0);
      checkOutput("wait_busy", busy_a, 1'b1);
      @(negedge clk);
      checkOutput("get_result", strobes_a, 3'b001);
      if (check_b) begin
         checkOutput("b_get_result", strobes_b, 3'b001);
         checkOutput("b_no_timeout", terr_b, 1'b0);
      end
      ifa.mx_state = OUTPUT_RESULT;
      ifa.mx_outp  = {$urandom, $urandom};
      @(negedge clk);
      ifa.mx_outp  = {$urandom, $urandom};
      checkOutput("capture_busy", busy_a, 1'b1);
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         word = fixed_words ? (64'hA5A5_0000_0000_0000 + 64'(j)) : {$urandom, $urandom};
         ifa.mx_outp = word;
         if (j == abort_word) begin
            #2 reset = 1'b1;
            #1;
            checkOutput("reset_strobes", strobes_a, 3'b000);
            checkOutput("reset_mx_inp", ifa.mx_inp, 64'd0);
            checkOutput("reset_flags", {busy_a, done_a, terr_a}, 3'b000);
            if (check_b) checkOutput("b_reset_flags", {strobes_b, busy_b, done_b, terr_b}, 6'd0);
            return;
         end
         res_model[j] = word;
      end
      @(negedge clk);
      checkOutput("done_flags", {busy_a, done_a, terr_a}, 3'b010);
      if (check_b) checkOutput("b_done_flags", {busy_b, done_b, terr_b}, 3'b010);
      ifa.mx_state = TERMINAL;
      ifa.mx_outp  = 64'd0;
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         rd_addr = 6'(j);
         #1;
         checkOutput($sformatf("res_word%0d", j), rd_data_a, res_model[j]);
         if (check_b) checkOutput($sformatf("b_res_word%0d", j), rd_data_b, res_model[j]);
      end
   endtask

   // Directed sequence of scenarios with randomized data and latencies.
   initial begin
      logic [63:0] val;
      reset        = 1'b1;
      wr_en        = 1'b0;
      go           = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      rd_addr      = '0;
      ifa.mx_state = NONE;
      ifa.mx_outp  = '0;
      #1;
      checkOutput("reset_state_flags", {busy_a, done_a, terr_a}, 3'b000);
      checkOutput("reset_state_strobes", strobes_a, 3'b000);
      checkOutput("reset_state_mx_inp", ifa.mx_inp, 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      $display("[TB] loading c_buf with k+1");
      for (int k = 0; k < N; k++) begin
         applyStimulus(1'b1, 6'(k), 64'(k + 1), 1'b0);
         c_model[k] = 64'(k + 1);
      end
      applyStimulus(1'b0, 6'd0, 64'd0, 1'b0);

      $display("[TB] run 1: fixed result pattern, writes and go during LOAD");
      runOp($urandom_range(1, 40), -1, 1'b1, 1'b1, 1'b1);

      $display("[TB] run 2: random operand written from DONE");
      for (int k = 0; k < N; k++) begin
         val = {$urandom, $urandom};
         applyStimulus(1'b1, 6'(k), val, 1'b0);
         c_model[k] = val;
      end
      applyStimulus(1'b0, 6'd0, 64'd0, 1'b0);
      runOp($urandom_range(1, 49), -1, 1'b1, 1'b0, 1'b0);

      $display("[TB] run 3: exponentiator never completes");
      runOp(0, -1, 1'b0, 1'b0, 1'b0);

      $display("[TB] run 4: write from ERR then restart");
      val = {$urandom, $urandom};
      applyStimulus(1'b1, 6'd7, val, 1'b0);
      c_model[7] = val;
      applyStimulus(1'b0, 6'd0, 64'd0, 1'b0);
      runOp($urandom_range(1, 49), -1, 1'b1, 1'b0, 1'b0);

      $display("[TB] run 5: COMPLETE coincides with 50-cycle watchdog");
      runOp(50, -1, 1'b1, 1'b0, 1'b0);

      $display("[TB] run 6: reset during capture of word 10");
      runOp($urandom_range(1, 49), 10, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j <= 10; j++) begin
         @(negedge clk);
         rd_addr = 6'(j);
         #1;
         checkOutput($sformatf("kept_res_word%0d", j), rd_data_a, res_model[j]);
      end
      checkOutput("strobes_during_reset", strobes_a, 3'b000);
      ifa.mx_state = NONE;
      ifa.mx_outp  = '0;
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] run 7: full run after reset");
      runOp($urandom_range(1, 49), -1, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/modexp_host.md
MODEXP_HOST -- requirements
Module: modexp_host

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one operand/result word.
REQ-002 Parameter TOTAL_ADDR, default 64, number of words per 4096-bit operand.
REQ-003 Parameter TIMEOUT_CYCLES, default 0; maximum WAIT_DONE cycles, where 0 disables the watchdog.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wr_en / wr_addr / wr_data  in  1 / log2(TOTAL_ADDR) / DATA_WIDTH  host write of operand c into the c buffer.
REQ-007 go  in  1  host request to run one exponentiation.
REQ-008 rd_addr  in  log2(TOTAL_ADDR)  result buffer read address; rd_data  out  DATA_WIDTH  combinational read of the result buffer.
REQ-009 busy / done / timeout_err  out  1 each  status flags.
REQ-010 start_input / start_compute / get_result  out  1 each  single-cycle strobes to the exponentiator.
REQ-011 mx_inp  out  DATA_WIDTH  operand word stream to the exponentiator.
REQ-012 mx_state  in  5  exponentiator top-level state; mx_outp  in  DATA_WIDTH  exponentiator result word.

Function
REQ-013 The FSM states SHALL be IDLE, START_IN, LOAD, PAD, START_CALC, WAIT_DONE, GET_RES, CAPTURE, DONE and ERR.
REQ-014 In IDLE, DONE and ERR, wr_en SHALL write wr_data to c_buf[wr_addr]; in all other states, writes SHALL be ignored.
REQ-015 go SHALL be acted on in IDLE, DONE and ERR, moving the FSM to START_IN, clearing done and timeout_err, and setting busy; while busy, go SHALL be ignored.
REQ-016 START_IN: start_input=1 for exactly one cycle, then LOAD with word counter 0.
REQ-017 LOAD: mx_inp=c_buf[k] for k=0..TOTAL_ADDR-1 on consecutive cycles, with word 0 driven in the cycle immediately after the start_input cycle.
REQ-018 PAD: mx_inp=0 for exactly one cycle, matching the receiver's TOTAL_ADDR+1 load beats, then START_CALC.
REQ-019 START_CALC: start_compute=1 for exactly one cycle, then WAIT_DONE with the watchdog counter cleared.
REQ-020 WAIT_DONE: when mx_state equals the package constant COMPLETE, the FSM SHALL go to GET_RES.
REQ-021 WAIT_DONE timeout: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES first, the FSM SHALL go to ERR with timeout_err=1 and busy=0.
REQ-022 GET_RES: get_result=1 for exactly one cycle, then CAPTURE.
REQ-023 CAPTURE: with the get_result cycle sampled at edge G, result word j (j=0..TOTAL_ADDR-1) SHALL be taken from mx_outp at edge G+2+j into res_buf[j].
REQ-024 After the last word is captured, the FSM SHALL go to DONE with done=1 and busy=0.
REQ-025 Coincident COMPLETE and timeout in the same cycle: COMPLETE SHALL win.
REQ-026 Strobes SHALL never overlap, and mx_inp SHALL be 0 outside LOAD.
REQ-027 Word counter and watchdog SHALL be unsigned; the word counter SHALL not wrap (exit at TOTAL_ADDR-1) and the watchdog SHALL saturate.

Reset
REQ-028 Reset SHALL force state IDLE and zero all of: strobes, mx_inp, busy, done, timeout_err, counters.
REQ-029 Buffer contents SHALL be unaffected by reset.
REQ-030 Reset mid-operation SHALL abort immediately with no further strobes; the exponentiator shares the reset, so go afterwards restarts from START_IN.

Structure
REQ-031 DATA_WIDTH, TOTAL_ADDR and the 5-bit exponentiator state codes (NONE, LOADC, WAIT_COMPUTE, COMPLETE, OUTPUT_RESULT, TERMINAL) SHALL live in the shared parameter package, together with this block's FSM encoding.
REQ-032 c_buf and res_buf SHALL be one reusable sub-module, word_buf (1 write port, 1 async read port), instantiated twice.

Verification
REQ-033 Load c_buf[k]=k+1, pulse go -> start_input once; mx_inp=1..64 on the next 64 cycles, then one 0; start_compute one cycle later.
REQ-034 Behavioural exponentiator model returns word j=64'hA5A5_0000_0000_0000+j -> res_buf matches via rd_addr 0..63; done=1, busy=0.
REQ-035 TIMEOUT_CYCLES=100, mx_state never COMPLETE -> timeout_err=1 exactly 100 cycles after WAIT_DONE entry; no get_result.
REQ-036 go and wr_en (addr 5, data 64'hDEAD) during LOAD -> ignored; c_buf[5] and the stream unchanged.
REQ-037 Reset asserted during CAPTURE word 10 -> all outputs 0 asynchronously; new go after release -> complete correct run.
REQ-038 COMPLETE and timeout in the same cycle (TIMEOUT_CYCLES=50, COMPLETE at count 50) -> GET_RES taken, timeout_err=0.
